load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the ALU: it takes the ALU result as the effective address, together with the rs2 store data and the funct3 width code, and performs one load or store over a req/ack data-memory bus. While the access is in flight it stalls the single-cycle core, which freezes the PC and holds all LSU inputs stable. When the access finishes it returns sign- or zero-extended load data for register write-back. Misaligned accesses, illegal width codes and bus timeouts are reported as a one-cycle fault.

## Interface
- TIMEOUT_CYCLES, 255, number of cycles in BUS without mem_ack before a timeout fault; range ≥1
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- lsu_valid  in  1  a load/store instruction is present; held stable while stall=1
- is_store  in  1  1=store, 0=load
- funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- stall  out  1  freeze core this cycle
- done  out  1  one-cycle pulse: access complete (with or without fault)
- load_data  out  32  extended load result; valid when done=1 and fault=0, otherwise 0
- fault  out  1  one-cycle pulse coincident with done on error
- fault_cause  out  2  0 NONE, 1 MISALIGNED, 2 ILLEGAL_FUNCT3, 3 BUS_TIMEOUT
- mem_req  out  1  bus request, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}, registered
- mem_be  out  4  byte enables, registered; 4'b0000 for loads
- mem_wdata  out  32  lane-replicated store data, registered
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion strobe

## Operation
- FSM states: IDLE, BUS, DONE, ERR.
- IDLE, lsu_valid=0: no action.
- IDLE, lsu_valid=1: decode the access.
  - funct3 illegal goes to ERR, cause 2. Legal codes: loads {000,001,010,100,101}, stores {000,001,010}.
  - Else a misaligned access goes to ERR, cause 1. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Else go to BUS, registering mem_req=1, mem_we, mem_addr, mem_be and mem_wdata.
- Illegal funct3 takes priority over misalignment.
- BUS:
  - Bus outputs are held constant and the timeout counter increments.
  - mem_ack=1: deassert mem_req. For a load, register the extended data. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: deassert mem_req and go to ERR, cause 3.
  - If ack arrives in the same cycle the counter expires, the ack wins.
- DONE: done=1, then IDLE. lsu_valid is ignored in DONE and ERR (it is the retiring instruction).
- ERR: done=1, fault=1, fault_cause valid, load_data=0, then IDLE. No bus request is ever issued for cause 1 or 2.
- mem_ack outside BUS is ignored (late ack after a timeout or after reset).
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{store_data[15:0]}}.
  - SW: be=4'b1111, wdata=store_data.
- Load extraction:
  - Byte = mem_rdata[8*addr[1:0] +: 8]; halfword = mem_rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- stall = (state==IDLE && lsu_valid) || state==BUS. stall is combinational; it is low in DONE and ERR.

## Timing
- Reset (synchronous): state=IDLE, counter=0, and every output is 0 (including mem_* and load_data).
- Reset in BUS: mem_req is low after that edge, and the pending access is abandoned with no done pulse.
- Minimum latency, ack in first BUS cycle:
  - cycle 0 IDLE decode with stall=1;
  - cycle 1 BUS, mem_req=1, ack;
  - cycle 2 DONE, stall=0.
  - Total: 3 cycles, with the core advancing at the end of cycle 2.
- Ack after n BUS cycles: done in cycle n+1.
- Decode fault: cycle 0 IDLE with stall=1, cycle 1 ERR.
- Timeout: ERR occurs in the cycle after the TIMEOUT_CYCLES-th BUS cycle.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and clears on entering BUS.

## Structure
- lsu_pkg:
  - state_t enum;
  - fault_cause_t enum;
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_align: purely combinational. Inputs are funct3, addr[1:0], store_data and mem_rdata. Outputs are be, wdata, load_ext and misaligned. The top module holds the FSM, counter and registers.

## Test plan
- SW addr=0x104, data=0xDEADBEEF, ack in first BUS cycle
  - → mem_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1.
  - → done in cycle 2, stall high cycles 0-1.
- LB addr=0x203, mem_rdata=0x80000000 → load_data=0xFFFFFF80. LBU with same data → 0x00000080.
- SH addr=0x202, data=0x1234ABCD → be=1100, wdata=0xABCDABCD. LH addr=0x202, rdata=0x7FFF0000 → load_data=0x00007FFF.
- Decode faults:
  - LW addr=0x102 → fault=1, cause=1, mem_req never asserted.
  - SB with funct3=100 → cause=2.
- TIMEOUT_CYCLES=4, no ack:
  - → ERR after 4 BUS cycles, cause=3, mem_req low.
  - → a later stray ack is ignored and does not pulse done.
- Ack in the same cycle as timeout expiry → normal DONE, no fault. Reset asserted in BUS → all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and width codes for the load/store unit: FSM states,
// fault causes, RISC-V funct3 encodings and the funct3 legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE           = 2'd0,
    FC_MISALIGNED     = 2'd1,
    FC_ILLEGAL_FUNCT3 = 2'd2,
    FC_BUS_TIMEOUT    = 2'd3
  } fault_cause_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths only exist for loads; stores accept B/H/W.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !is_store;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// load byte/halfword extraction with sign/zero extension, and alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_mem_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_ext,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_mem_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    o_be         = 4'b0000;
    o_wdata      = i_store_data;
    o_load_ext   = i_mem_rdata;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be       = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_store_data[7:0]}};
        o_load_ext = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: o_load_ext = {24'd0, w_byte};
      F3_H: begin
        o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata      = {2{i_store_data[15:0]}};
        o_load_ext   = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      F3_HU: begin
        o_load_ext   = {16'd0, w_half};
        o_misaligned = i_addr_lo[0];
      end
      F3_W: begin
        o_be         = 4'b1111;
        o_misaligned = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: decodes one access, runs it over a req/ack bus
// with a timeout, and returns extended load data or a one-cycle fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state, w_next_state;
  fault_cause_t       r_cause, w_next_cause;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_load_data;
  logic               r_mem_req, r_mem_we;
  logic [31:0]        r_mem_addr, r_mem_wdata;
  logic [3:0]         r_mem_be;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata, w_load_ext;
  logic               w_misaligned;

  lsu_align u_align (
    .i_funct3     (funct3),
    .i_addr_lo    (addr[1:0]),
    .i_store_data (store_data),
    .i_mem_rdata  (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_ext   (w_load_ext),
    .o_misaligned (w_misaligned)
  );

  // Illegal funct3 is checked before alignment so it wins when both apply.
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_cause;
    case (r_state)
      IDLE: if (lsu_valid) begin
        if (!funct3_legal(is_store, funct3)) begin
          w_next_state = ERR;
          w_next_cause = FC_ILLEGAL_FUNCT3;
        end else if (w_misaligned) begin
          w_next_state = ERR;
          w_next_cause = FC_MISALIGNED;
        end else begin
          w_next_state = BUS;
        end
      end
      BUS: if (mem_ack) begin
        w_next_state = DONE;
      end else if (r_cnt == CNT_LAST) begin
        w_next_state = ERR;
        w_next_cause = FC_BUS_TIMEOUT;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      r_state     <= IDLE;
      r_cause     <= FC_NONE;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_cause <= w_next_cause;
      case (r_state)
        IDLE: if (w_next_state == BUS) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= is_store;
          r_mem_addr  <= {addr[31:2], 2'b00};
          r_mem_be    <= is_store ? w_be : 4'b0000;
          r_mem_wdata <= is_store ? w_wdata : 32'd0;
          r_cnt       <= '0;
          r_load_data <= '0;
        end
        BUS: if (w_next_state != BUS) begin
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_be    <= '0;
          r_mem_wdata <= '0;
          if (mem_ack && !r_mem_we) r_load_data <= w_load_ext;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall       = (r_state == IDLE && lsu_valid) || r_state == BUS;
  assign done        = (r_state == DONE) || (r_state == ERR);
  assign fault       = (r_state == ERR);
  assign fault_cause = (r_state == ERR) ? r_cause : FC_NONE;
  assign load_data   = (r_state == DONE) ? r_load_data : 32'd0;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_be      = r_mem_be;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES=4: stores, loads,
// decode faults, bus timeout, ack-at-expiry and reset during a bus access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, lsu_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;
  logic        mem_ack;
  logic        stall, done, fault, mem_req, mem_we;
  logic [1:0]  fault_cause;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  // Results captured by run_access.
  logic [31:0] o_ld;
  logic        o_fault, o_saw_req, o_req_at_done, o_we;
  logic [1:0]  o_cause;
  int          o_lat;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic [15:0] o_stall;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .lsu_valid(lsu_valid), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .done(done), .load_data(load_data), .fault(fault),
    .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Issue one access; ack_after = BUS cycle in which ack is driven (0 = never).
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd, input int ack_after);
    int cyc = 0;
    int bus_n = 0;
    logic got = 1'b0;
    @(negedge clk);
    lsu_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    mem_rdata = rd; mem_ack = 1'b0;
    o_saw_req = 1'b0; o_stall = '0; o_lat = -1;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
    while (!got && cyc < 16) begin
      #1;
      o_stall[cyc] = stall;
      if (mem_req) begin
        bus_n++;
        if (!o_saw_req) begin
          o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        end
        o_saw_req = 1'b1;
        mem_ack = (bus_n == ack_after);
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        o_lat = cyc; o_ld = load_data; o_fault = fault; o_cause = fault_cause;
        o_req_at_done = mem_req;
        lsu_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    lsu_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL access_done_bound: no done within %0d cycles, required done", cyc);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({stall, done, fault, fault_cause} !== 5'd0) begin
      errors++; $display("FAIL reset_status: got %b, required 00000", {stall, done, fault, fault_cause});
    end
    checks++;
    if ({mem_req, mem_we, mem_be} !== 6'd0) begin
      errors++; $display("FAIL reset_bus_ctl: got %b, required 000000", {mem_req, mem_we, mem_be});
    end
    checks++;
    if ({mem_addr, mem_wdata, load_data} !== 96'd0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", {mem_addr, mem_wdata, load_data});
    end
  endtask

  task automatic test_store_word();
    run_access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1);
    checks++;
    if ({o_we, o_be, o_addr} !== {1'b1, 4'b1111, 32'h104}) begin
      errors++; $display("FAIL sw_bus: we=%b be=%b addr=%h, required 1 1111 00000104", o_we, o_be, o_addr);
    end
    checks++;
    if (o_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_wdata: got %h, required deadbeef", o_wdata);
    end
    checks++;
    if (o_lat !== 2 || o_stall[2:0] !== 3'b011 || o_fault !== 1'b0) begin
      errors++; $display("FAIL sw_timing: lat=%0d stall=%b fault=%b, required 2 011 0", o_lat, o_stall[2:0], o_fault);
    end
  endtask

  task automatic test_load_byte();
    run_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80000000, 1);
    checks++;
    if (o_ld !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_sign: got %h, required ffffff80", o_ld);
    end
    checks++;
    if (o_we !== 1'b0 || o_be !== 4'b0000 || o_addr !== 32'h200) begin
      errors++; $display("FAIL lb_bus: we=%b be=%b addr=%h, required 0 0000 00000200", o_we, o_be, o_addr);
    end
    run_access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80000000, 1);
    checks++;
    if (o_ld !== 32'h00000080) begin
      errors++; $display("FAIL lbu_zero: got %h, required 00000080", o_ld);
    end
  endtask

  task automatic test_halfword();
    run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1);
    checks++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD) begin
      errors++; $display("FAIL sh_lanes: be=%b wdata=%h, required 1100 abcdabcd", o_be, o_wdata);
    end
    run_access(1'b0, 3'b001, 32'h202, 32'h0, 32'h7FFF0000, 1);
    checks++;
    if (o_ld !== 32'h00007FFF) begin
      errors++; $display("FAIL lh_upper: got %h, required 00007fff", o_ld);
    end
    run_access(1'b0, 3'b001, 32'h200, 32'h0, 32'h00008001, 1);
    checks++;
    if (o_ld !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh_sign: got %h, required ffff8001", o_ld);
    end
    run_access(1'b0, 3'b101, 32'h200, 32'h0, 32'h00008001, 1);
    checks++;
    if (o_ld !== 32'h00008001) begin
      errors++; $display("FAIL lhu_zero: got %h, required 00008001", o_ld);
    end
  endtask

  task automatic test_load_word_slow();
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 3);
    checks++;
    if (o_ld !== 32'h12345678 || o_lat !== 4 || o_fault !== 1'b0) begin
      errors++; $display("FAIL lw_ack3: data=%h lat=%0d fault=%b, required 12345678 4 0", o_ld, o_lat, o_fault);
    end
  endtask

  task automatic test_decode_faults();
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 1);
    checks++;
    if ({o_fault, o_cause, o_saw_req} !== 4'b1010 || o_lat !== 1 || o_ld !== 32'd0) begin
      errors++; $display("FAIL lw_misaligned: fault=%b cause=%0d req=%b lat=%0d ld=%h, required 1 1 0 1 0",
                         o_fault, o_cause, o_saw_req, o_lat, o_ld);
    end
    run_access(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 1);
    checks++;
    if ({o_fault, o_cause, o_saw_req} !== 4'b1100) begin
      errors++; $display("FAIL sb_f3_100: fault=%b cause=%0d req=%b, required 1 2 0", o_fault, o_cause, o_saw_req);
    end
    run_access(1'b1, 3'b011, 32'h101, 32'h55, 32'h0, 1);
    checks++;
    if ({o_fault, o_cause, o_saw_req} !== 4'b1100) begin
      errors++; $display("FAIL illegal_over_misaligned: fault=%b cause=%0d req=%b, required 1 2 0",
                         o_fault, o_cause, o_saw_req);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0);
    checks++;
    if ({o_fault, o_cause, o_req_at_done} !== 4'b1110 || o_lat !== 5 || o_ld !== 32'd0) begin
      errors++; $display("FAIL timeout: fault=%b cause=%0d req=%b lat=%0d ld=%h, required 1 3 0 5 0",
                         o_fault, o_cause, o_req_at_done, o_lat, o_ld);
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL stray_ack_now: done=%b fault=%b, required 0 0", done, fault);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL stray_ack_after: done=%b req=%b stall=%b, required 0 0 0", done, mem_req, stall);
    end
  endtask

  task automatic test_ack_at_expiry();
    run_access(1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADCAFE, 4);
    checks++;
    if (o_fault !== 1'b0 || o_lat !== 5 || o_ld !== 32'h0BADCAFE) begin
      errors++; $display("FAIL ack_at_expiry: fault=%b lat=%0d ld=%h, required 0 5 0badcafe", o_fault, o_lat, o_ld);
    end
  endtask

  task automatic test_reset_in_bus();
    @(negedge clk);
    lsu_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h300; store_data = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_bus_pre: mem_req=%b, required 1", mem_req);
    end
    reset = 1'b1; lsu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, done, fault, fault_cause, mem_req, mem_we, mem_be} !== 11'd0 ||
        {mem_addr, mem_wdata, load_data} !== 96'd0) begin
      errors++; $display("FAIL rst_in_bus: ctl=%b data=%h, required all 0",
                         {stall, done, fault, fault_cause, mem_req, mem_we, mem_be}, {mem_addr, mem_wdata, load_data});
    end
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_abandon: done=%b req=%b, required 0 0", done, mem_req);
    end
  endtask

  initial begin
    reset = 1'b1; lsu_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_store_word();
    test_load_byte();
    test_halfword();
    test_load_word_slow();
    test_decode_faults();
    test_timeout();
    test_ack_at_expiry();
    test_reset_in_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
